// File: rtl/dmem_request_queue.sv
// dmem_request_queue
// In-order load/store request queue between the pipeline MEM stage and the
// data cache port. Requests are buffered (up to DEPTH) and issued one at a
// time as held dmemREN/dmemWEN strobes that drop after dhit. Load data is
// returned as a one-cycle rsp_valid pulse. The block also owns imemREN and
// drops it only once halt is seen and the queue has fully drained.
//
// Optional build macro: DRQ_STALL_CNT_EN adds a saturating 32-bit
// stall_cycles counter output.
//
// FSM states:
//   state | meaning
//   IDLE  | no access in flight; launch head entry (or an incoming push
//         | into an empty queue) on the next edge
//   ISSUE | strobes held on the memory port, waiting for dhit
module dmem_request_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_wen,
  input  logic [AW-1:0]              req_addr,
  input  logic [DW-1:0]              req_wdata,
  input  logic                       halt,
  output logic                       dmemREN,
  output logic                       dmemWEN,
  output logic [AW-1:0]              dmemaddr,
  output logic [DW-1:0]              dmemstore,
  input  logic                       dhit,
  input  logic [DW-1:0]              dmemload,
  output logic                       rsp_valid,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       imemREN,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DRQ_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic             q_wen   [DEPTH];
  logic [AW-1:0]    q_addr  [DEPTH];
  logic [DW-1:0]    q_wdata [DEPTH];

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             launch;
  logic             head_wen;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_wdata;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign req_ready = !full && !halt;
  assign push      = req_valid && req_ready;
  // the in-flight entry stays in the queue until its dhit, so pop == completion
  assign pop       = (state == ISSUE) && dhit;
  assign launch    = (state == IDLE) && (!empty || push);
  assign busy      = !empty;
  assign imemREN   = !(halt && empty);

  // Head entry; an empty queue forwards the incoming request so a push can
  // reach the memory port on the very next edge.
  always_comb begin
    head_wen   = q_wen[rd_ptr];
    head_addr  = q_addr[rd_ptr];
    head_wdata = q_wdata[rd_ptr];
    if (empty) begin
      head_wen   = req_wen;
      head_addr  = req_addr;
      head_wdata = req_wdata;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_wen[wr_ptr]   <= req_wen;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
    end
  end

  // Pointers wrap naturally; count tells full from empty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered memory-port strobes and load response.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            dmemaddr  <= head_addr;
            dmemstore <= head_wdata;
            dmemREN   <= !head_wen;
            dmemWEN   <= head_wen;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (dhit) begin
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            rsp_valid <= dmemREN;
            if (dmemREN) rsp_rdata <= dmemload;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRQ_STALL_CNT_EN
  logic stall_now;
  assign stall_now = (req_valid && !req_ready) || ((state == ISSUE) && !dhit);

  // Saturating count of cycles lost to back-pressure or memory wait.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_request_queue.sv
// Scoreboard bench for dmem_request_queue: the driver pushes expected memory
// accesses and load responses when a request is accepted; a monitor pops
// them as the DUT presents strobes / rsp_valid. A small memory responder
// drives dhit/dmemload with fixed or random latency.
module tb_dmem_request_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          halt = 1'b0;
  logic          dhit = 1'b0;
  logic [DW-1:0] dmemload = '0;
  logic          req_ready;
  logic          dmemREN;
  logic          dmemWEN;
  logic [AW-1:0] dmemaddr;
  logic [DW-1:0] dmemstore;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          imemREN;
  logic          busy;
  logic [CW-1:0] count;
`ifdef DRQ_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  dmem_request_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .imemREN(imemREN),
    .busy(busy), .count(count)
`ifdef DRQ_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_rsp[$];

  // responder controls
  bit resp_en   = 1'b0;
  bit lat_rand  = 1'b0;
  int lat_fixed = 1;
  int lat_cur   = 1;
  int held      = 0;

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", n, a, e);
    end
  endtask

  task automatic chkv(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  // memory model: dhit after the strobe has been seen for lat_cur cycles
  always @(negedge CLK) begin
    dhit     = 1'b0;
    dmemload = 32'hBAD0_BAD0;
    if (!nRST) begin
      held = 0;
    end else if (dmemREN || dmemWEN) begin
      if (held == 0) lat_cur = lat_rand ? int'($urandom_range(4, 1)) : lat_fixed;
      held++;
      if (resp_en && held >= lat_cur) begin
        dhit = 1'b1;
        if (dmemREN) dmemload = mem_data(dmemaddr);
        held = 0;
      end
    end else begin
      held = 0;
    end
  end

  // monitor: match each new access and each load response against the scoreboard
  logic        prev_stb = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_store = '0;
  always @(negedge CLK) begin
    acc_t        e;
    logic [31:0] r;
    if (!nRST) begin
      prev_stb = 1'b0;
    end else begin
      if (dmemREN || dmemWEN) begin
        chk1("one_strobe", dmemREN && dmemWEN, 1'b0);
        if (!prev_stb) begin
          if (exp_acc.size() == 0) begin
            checks++; errors++;
            $display("FAIL acc_unexpected: got addr %0h expected no access", dmemaddr);
          end else begin
            e = exp_acc.pop_front();
            chk1("acc_wen", dmemWEN, e.wen);
            chkv("acc_addr", dmemaddr, e.addr);
            if (e.wen) chkv("acc_wdata", dmemstore, e.wdata);
          end
          cur_addr  = dmemaddr;
          cur_store = dmemstore;
        end else begin
          chkv("acc_addr_held", dmemaddr, cur_addr);
          chkv("acc_store_held", dmemstore, cur_store);
        end
      end
      prev_stb = dmemREN || dmemWEN;
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rdata %0h expected no response", rsp_rdata);
        end else begin
          r = exp_rsp.pop_front();
          chkv("rsp_rdata", rsp_rdata, r);
        end
      end
    end
  end

  // present a request (call right after a negedge); record it if accepted
  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic acc);
    req_valid = 1'b1;
    req_wen   = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    acc = req_ready;
    if (acc) begin
      exp_acc.push_back('{wen: w, addr: a, wdata: d});
      if (!w) exp_rsp.push_back(mem_data(a));
    end
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge CLK);
      offer(w, a, d, acc);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no accept expected accept for addr %0h", a);
    end
  endtask

  task automatic release_req();
    @(negedge CLK);
    req_valid = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input string n);
    int k;
    k = 0;
    while ((busy || dmemREN || dmemWEN) && k < 400) begin
      @(negedge CLK);
      #1;
      k++;
    end
    chk1({n, "_drained"}, busy, 1'b0);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic acc;
    int   k;

    // reset state
    repeat (2) @(negedge CLK);
    #1;
    chk1("rst_dmemREN", dmemREN, 1'b0);
    chk1("rst_dmemWEN", dmemWEN, 1'b0);
    chkv("rst_dmemaddr", dmemaddr, 32'h0);
    chkv("rst_dmemstore", dmemstore, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chkv("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_imemREN", imemREN, 1'b1);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chkv("rst_count", 32'(count), 32'd0);
`ifdef DRQ_STALL_CNT_EN
    chkv("rst_stall", stall_cycles, 32'd0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    #1;

    // single load: push cycle 0, dhit cycle 3
    resp_en = 1'b1; lat_rand = 1'b0; lat_fixed = 3;
    @(negedge CLK);
    offer(1'b0, 32'h100, 32'h0, acc);
    chk1("ld_accept", acc, 1'b1);
    @(negedge CLK); req_valid = 1'b0; #1;
    chk1("ld_c1_ren", dmemREN, 1'b1);
    chkv("ld_c1_addr", dmemaddr, 32'h100);
    chk1("ld_c1_busy", busy, 1'b1);
    chkv("ld_c1_count", 32'(count), 32'd1);
    @(negedge CLK); #1;
    chk1("ld_c2_ren", dmemREN, 1'b1);
    @(negedge CLK); #1;
    chk1("ld_c3_ren", dmemREN, 1'b1);
    chk1("ld_c3_rsp", rsp_valid, 1'b0);
    @(negedge CLK); #1;
    chk1("ld_c4_ren", dmemREN, 1'b0);
    chk1("ld_c4_rsp", rsp_valid, 1'b1);
    chkv("ld_c4_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk1("ld_c4_busy", busy, 1'b0);
    @(negedge CLK); #1;
    chk1("ld_c5_rsp", rsp_valid, 1'b0);
    chkv("ld_c5_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
`ifdef DRQ_STALL_CNT_EN
    chkv("ld_stall", stall_cycles, 32'd2);
`endif

    // single store: dhit after 2 cycles
    lat_fixed = 2;
    @(negedge CLK);
    offer(1'b1, 32'h40, 32'h1234_5678, acc);
    chk1("st_accept", acc, 1'b1);
    @(negedge CLK); req_valid = 1'b0; #1;
    chk1("st_c1_wen", dmemWEN, 1'b1);
    chk1("st_c1_ren", dmemREN, 1'b0);
    chkv("st_c1_store", dmemstore, 32'h1234_5678);
    chkv("st_c1_addr", dmemaddr, 32'h40);
    @(negedge CLK); #1;
    chk1("st_c2_wen", dmemWEN, 1'b1);
    chk1("st_c2_ren", dmemREN, 1'b0);
    @(negedge CLK); #1;
    chk1("st_c3_wen", dmemWEN, 1'b0);
    chk1("st_c3_rsp", rsp_valid, 1'b0);
    chk1("st_c3_busy", busy, 1'b0);
    @(negedge CLK); #1;
    chk1("st_c4_rsp", rsp_valid, 1'b0);
`ifdef DRQ_STALL_CNT_EN
    chkv("st_stall", stall_cycles, 32'd3);
`endif

    // fill / full with the memory stalled
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      offer(1'b0, 32'h200 + 32'(4 * i), 32'h0, acc);
      chk1("fill_accept", acc, 1'b1);
    end
    @(negedge CLK);
    offer(1'b0, 32'h300, 32'h0, acc);
    chk1("fill_5th_rejected", acc, 1'b0);
    chkv("fill_count", 32'(count), 32'd4);
    @(negedge CLK); req_valid = 1'b0; #1;
    chkv("fill_count_hold", 32'(count), 32'd4);
    chk1("fill_ready_low", req_ready, 1'b0);
    resp_en = 1'b1; lat_fixed = 1;
    @(negedge CLK); #1;
    resp_en = 1'b0;
    @(negedge CLK); #1;
    chkv("fill_count_after_hit", 32'(count), 32'd3);
    chk1("fill_ready_after_hit", req_ready, 1'b1);
    resp_en = 1'b1;
    wait_drain("fill");

    // ordering and wrap: alternating loads/stores, random latency
    lat_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_req(1'(i % 2), 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    release_req();
    wait_drain("order");
    lat_rand = 1'b0;

    // halt drain
    resp_en = 1'b0;
    push_req(1'b0, 32'h500, 32'h0);
    push_req(1'b1, 32'h504, 32'h5555_AAAA);
    push_req(1'b0, 32'h508, 32'h0);
    release_req();
    @(negedge CLK);
    halt = 1'b1;
    #1;
    chk1("halt_ready_low", req_ready, 1'b0);
    chk1("halt_imem_busy", imemREN, 1'b1);
    chkv("halt_count", 32'(count), 32'd3);
    @(negedge CLK);
    offer(1'b0, 32'h600, 32'h0, acc);
    chk1("halt_push_rejected", acc, 1'b0);
    resp_en = 1'b1; lat_fixed = 2;
    k = 0;
    while (busy && k < 100) begin
      chk1("halt_imem_during_drain", imemREN, 1'b1);
      @(negedge CLK); #1;
      k++;
    end
    chkv("halt_drained_count", 32'(count), 32'd0);
    chk1("halt_imem_off", imemREN, 1'b0);
    @(negedge CLK);
    req_valid = 1'b0;
    halt = 1'b0;
    #1;
    chk1("unhalt_ready", req_ready, 1'b1);
    chk1("unhalt_imem", imemREN, 1'b1);

    // reset in the middle of an access
    resp_en = 1'b0;
    push_req(1'b0, 32'h700, 32'h0);
    push_req(1'b0, 32'h704, 32'h0);
    release_req();
    chk1("mid_ren_before", dmemREN, 1'b1);
    chkv("mid_count_before", 32'(count), 32'd2);
    #1;
    nRST = 1'b0;
    #1;
    exp_acc.delete();
    exp_rsp.delete();
    chk1("mid_rst_ren", dmemREN, 1'b0);
    chk1("mid_rst_wen", dmemWEN, 1'b0);
    chkv("mid_rst_count", 32'(count), 32'd0);
`ifdef DRQ_STALL_CNT_EN
    chkv("mid_rst_stall", stall_cycles, 32'd0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk1("post_rst_rsp", rsp_valid, 1'b0);
      chkv("post_rst_count", 32'(count), 32'd0);
      chk1("post_rst_imem", imemREN, 1'b1);
      chk1("post_rst_ren", dmemREN, 1'b0);
    end

    chkv("sb_acc_empty", 32'(exp_acc.size()), 32'd0);
    chkv("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
